// File: rtl/fetch_sequencer.sv
// fetch_sequencer: phase counter, instruction register, program counter,
// halt latch and retired-instruction counter for the 8-phase accumulator CPU.
// The decoder strobes (sel, ld_ir, inc_pc, ld_pc, halt) are applied on the
// next rising edge. The memory address mux is purely combinational.
//
// Mode table:
//   state        | meaning
//   MODE_RUN     | phases advance on every enabled edge
//   MODE_HALTED  | all state frozen, left only through rst
module fetch_sequencer #(
  parameter int AWIDTH = 5,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [AWIDTH+2:0] data_in,
  input  logic              sel,
  input  logic              ld_ir,
  input  logic              inc_pc,
  input  logic              ld_pc,
  input  logic              halt,
  output logic [2:0]        ph,
  output logic [2:0]        op,
  output logic [AWIDTH-1:0] ir_addr,
  output logic [AWIDTH-1:0] pc,
  output logic [AWIDTH-1:0] addr,
  output logic              halted,
  output logic [CWIDTH-1:0] instr_cnt
);

  localparam int IWIDTH = AWIDTH + 3;
  localparam logic [AWIDTH-1:0] PC_ONE  = AWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

  typedef enum logic {
    MODE_RUN    = 1'b0,
    MODE_HALTED = 1'b1
  } mode_t;

  mode_t             mode_q, mode_d;
  logic [2:0]        ph_q, ph_d;
  logic [IWIDTH-1:0] ir_q, ir_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;

  // State register; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_RUN;
      ph_q   <= 3'd0;
      ir_q   <= '0;
      pc_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      ph_q   <= ph_d;
      ir_q   <= ir_d;
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic: halt wins over every other strobe on its edge, and
  // nothing moves on a stalled edge or once halted.
  always_comb begin
    mode_d = mode_q;
    ph_d   = ph_q;
    ir_d   = ir_q;
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    case (mode_q)
      MODE_RUN: begin
        if (enable) begin
          if (halt) begin
            mode_d = MODE_HALTED;
          end else begin
            ph_d = ph_q + 3'd1;
            if (ld_ir) begin
              ir_d = data_in;
            end
            if (ld_pc) begin
              pc_d = ir_q[AWIDTH-1:0];
            end else if (inc_pc) begin
              pc_d = pc_q + PC_ONE;
            end
            // The 7 -> 0 wrap retires one instruction; the count saturates.
            if ((ph_q == 3'd7) && (cnt_q != CNT_MAX)) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end
      MODE_HALTED: begin
        mode_d = MODE_HALTED;
      end
      default: begin
        mode_d = MODE_HALTED;
      end
    endcase
  end

  // Output decode and the live address mux.
  always_comb begin
    ph        = ph_q;
    op        = ir_q[IWIDTH-1:AWIDTH];
    ir_addr   = ir_q[AWIDTH-1:0];
    pc        = pc_q;
    halted    = (mode_q == MODE_HALTED);
    instr_cnt = cnt_q;
    addr      = sel ? pc_q : ir_q[AWIDTH-1:0];
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a vector table for the basic
// run sequence plus hand-written sequences for wrap, halt, stall, counter
// saturation and asynchronous reset.
module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW+2:0] data_in = '0;
  logic          sel = 1'b0;
  logic          ld_ir = 1'b0;
  logic          inc_pc = 1'b0;
  logic          ld_pc = 1'b0;
  logic          halt = 1'b0;
  logic [2:0]    ph;
  logic [2:0]    op;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] pc;
  logic [AW-1:0] addr;
  logic          halted;
  logic [CW-1:0] instr_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_sequencer #(.AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .sel(sel),
    .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .halt(halt),
    .ph(ph), .op(op), .ir_addr(ir_addr), .pc(pc), .addr(addr),
    .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [7:0]    din;
    logic          s;
    logic          lir;
    logic          inc;
    logic          lpc;
    logic          hlt;
    logic [2:0]    e_ph;
    logic [2:0]    e_op;
    logic [4:0]    e_ira;
    logic [4:0]    e_pc;
    logic [4:0]    e_addr;
    logic          e_halted;
    logic [2:0]    e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_ph, input logic [2:0] e_op,
                           input logic [4:0] e_ira, input logic [4:0] e_pc, input logic [4:0] e_addr,
                           input logic e_halted, input logic [2:0] e_cnt);
    check({tag, ".ph"}, 32'(ph), 32'(e_ph));
    check({tag, ".op"}, 32'(op), 32'(e_op));
    check({tag, ".ir_addr"}, 32'(ir_addr), 32'(e_ira));
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".addr"}, 32'(addr), 32'(e_addr));
    check({tag, ".halted"}, 32'(halted), 32'(e_halted));
    check({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(e_cnt));
  endtask

  task automatic idle_inputs();
    enable = 1'b1; data_in = '0; sel = 1'b1;
    ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0; halt = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    enable = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] h_op;
    logic [4:0] h_ira;

    //              en din    s lir inc lpc hlt | ph op ira pc addr hlt cnt
    for (int i = 1; i <= 7; i++)
      vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'(i), 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd5, 5'd3, 5'd0, 5'd3, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd5, 5'd3, 5'd0, 5'd0, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 3'd5, 5'd3, 5'd3, 5'd3, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 5'd3, 5'd4, 5'd4, 1'b0, 3'd1});
    vecs.push_back('{1'b0, 8'h1F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 5'd3, 5'd4, 5'd4, 1'b0, 3'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd5, 5'd3, 5'd4, 5'd4, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd2, 5'd9, 5'd4, 5'd9, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd7, 3'd2, 5'd9, 5'd9, 5'd9, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 5'd9, 5'd9, 5'd9, 1'b0, 3'd2});

    // Reset state.
    do_reset();
    sel = 1'b1;
    #1;
    check_all("reset", 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0);

    // Table-driven run sequence.
    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; data_in = vecs[i].din; sel = vecs[i].s;
      ld_ir = vecs[i].lir; inc_pc = vecs[i].inc; ld_pc = vecs[i].lpc; halt = vecs[i].hlt;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_ph, vecs[i].e_op, vecs[i].e_ira,
                vecs[i].e_pc, vecs[i].e_addr, vecs[i].e_halted, vecs[i].e_cnt);
    end

    // PC wrap 31 -> 0.
    do_reset();
    idle_inputs(); ld_ir = 1'b1; data_in = 8'h1F; step();
    idle_inputs(); ld_pc = 1'b1; step();
    check("wrap.pc31", 32'(pc), 32'd31);
    idle_inputs(); inc_pc = 1'b1; step();
    check("wrap.pc0", 32'(pc), 32'd0);
    check("wrap.ph", 32'(ph), 32'd3);

    // Halt at ph 4 with pc 6, ir = E9 (op 7, addr 9).
    do_reset();
    idle_inputs(); ld_ir = 1'b1; data_in = 8'h06; step();
    idle_inputs(); ld_pc = 1'b1; step();
    idle_inputs(); ld_ir = 1'b1; data_in = 8'hE9; step();
    idle_inputs(); step();
    check("halt.pre_ph", 32'(ph), 32'd4);
    idle_inputs(); enable = 1'b0; halt = 1'b1; step();
    check("halt.stalled_no_halt", 32'(halted), 32'd0);
    idle_inputs(); halt = 1'b1; inc_pc = 1'b1; step();
    check_all("halt.enter", 3'd4, 3'd7, 5'd9, 5'd6, 5'd6, 1'b1, 3'd0);
    h_op = 3'd7; h_ira = 5'd9;
    for (int i = 0; i < 10; i++) begin
      enable = 1'b1; halt = 1'b0;
      ld_ir = 1'($urandom_range(0, 1)); ld_pc = 1'($urandom_range(0, 1));
      inc_pc = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      step();
      check_all($sformatf("halt.hold%0d", i), 3'd4, h_op, h_ira, 5'd6, sel ? 5'd6 : 5'd9, 1'b1, 3'd0);
    end

    // Stall at ph 2 with ld_ir and changing data.
    do_reset();
    idle_inputs(); step();
    idle_inputs(); step();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); enable = 1'b0; ld_ir = 1'b1; data_in = 8'(8'h71 + 8'(i * 17));
      step();
      check($sformatf("stall%0d.ph", i), 32'(ph), 32'd2);
      check($sformatf("stall%0d.ir", i), 32'({op, ir_addr}), 32'd0);
    end
    idle_inputs(); ld_ir = 1'b1; data_in = 8'h5A; step();
    check("stall.reen_ph", 32'(ph), 32'd3);
    check("stall.reen_ir", 32'({op, ir_addr}), 32'h5A);

    // Counter saturation at 2^CW-1.
    do_reset();
    idle_inputs();
    for (int i = 0; i < 56; i++) step();
    check("sat.reach", 32'(instr_cnt), 32'd7);
    for (int i = 0; i < 8; i++) step();
    check("sat.hold", 32'(instr_cnt), 32'd7);

    // Asynchronous reset mid-cycle at ph 5, pc 12, count 4.
    do_reset();
    idle_inputs();
    for (int i = 0; i < 32; i++) step();
    idle_inputs(); ld_ir = 1'b1; data_in = 8'h0C; step();
    idle_inputs(); ld_pc = 1'b1; step();
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    check_all("arst.pre", 3'd5, 3'd0, 5'd12, 5'd12, 5'd12, 1'b0, 3'd4);
    #2 rst = 1'b1;
    #1;
    check_all("arst.clear", 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst.restart_ph", 32'(ph), 32'd1);
    check("arst.restart_cnt", 32'(instr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Phase sequencer, instruction register and program counter for the 8-phase accumulator CPU. It generates the 3-bit phase `ph` and the decoded `op` consumed by the control decoder. It executes that decoder's `sel`, `ld_ir`, `inc_pc`, `ld_pc` and `halt` strobes on the next clock edge. It also drives the memory address mux and keeps a count of retired instructions.

## Interface
Parameters:
- `AWIDTH`, default 5: address width. Instruction word width is `AWIDTH+3`, laid out as {op[2:0], addr}.
- `CWIDTH`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: run gate; when low all state holds.
- `data_in`, in, AWIDTH+3: instruction word from memory.
- `sel`, in, 1: address select (1 = `pc`, 0 = `ir_addr`).
- `ld_ir`, in, 1: load instruction register.
- `inc_pc`, in, 1: increment program counter.
- `ld_pc`, in, 1: load program counter from `ir_addr`.
- `halt`, in, 1: halt request.
- `ph`, out, 3: current phase.
- `op`, out, 3: `ir[AWIDTH+2:AWIDTH]`.
- `ir_addr`, out, AWIDTH: `ir[AWIDTH-1:0]`.
- `pc`, out, AWIDTH: program counter.
- `addr`, out, AWIDTH: memory address.
- `halted`, out, 1: CPU stopped.
- `instr_cnt`, out, CWIDTH: retired instructions.

## Operation
- State: `ph`, `ir`, `pc`, `halted`, `instr_cnt`. There are two modes, RUN (`halted`=0) and HALTED (`halted`=1).
- An edge is "active" when `enable`=1 and `halted`=0. On any non-active edge, all state holds.
- Phase counter: on each active edge, `ph <= ph+1`. It wraps 7 -> 0.
- Instruction register: on an active edge with `ld_ir`=1, `ir <= data_in`. The decoder asserts `ld_ir` in both ph 2 and ph 3, so the same word loads twice.
- PC priority on an active edge:
  - `ld_pc`=1: `pc <= ir_addr`.
  - else `inc_pc`=1: `pc <= pc+1`, modulo 2^AWIDTH; 2^AWIDTH-1 wraps to 0.
  - else hold.
- Halt: on an active edge with `halt`=1:
  - `halted <= 1`.
  - `ph`, `ir` and `pc` hold; halt overrides `ld_ir`, `inc_pc` and `ld_pc` on that edge.
  - `pc` therefore still addresses the HALT instruction.
- HALTED mode is left only by `rst`.
- Retire count: on an active edge with `ph`=7 (wrap to 0), `instr_cnt <= instr_cnt+1`. It saturates at 2^CWIDTH-1. The HALT instruction is not counted.
- Address mux: `addr = sel ? pc : ir_addr`. It is purely combinational, with no state, and remains live in HALTED mode.

## Timing
- Reset values (asynchronous, immediate, any phase): `ph`=0, `ir`=0 (so `op`=0, `ir_addr`=0), `pc`=0, `halted`=0, `instr_cnt`=0.
- `ph`, `op`, `ir_addr`, `pc`, `halted` and `instr_cnt` are registered outputs; each changes one edge after the sampled strobe.
- `addr` follows `sel`, `pc` and `ir_addr` within the same cycle.
- `op` from the ld_ir edge of ph 2 is valid from ph 3, ahead of the decoder's ph 4 use.
- `halt` sampled while `ph`=4: `halted`=1 from the next cycle, and `ph` stays 4 indefinitely.
- `enable` low: the phase is stretched. Strobes presented during a stalled cycle have no effect; the decoder re-presents them, since they are a function of `ph` and `op`.
- Reset asserted mid-instruction: all state clears immediately. The first edge after deassertion with `enable`=1 moves `ph` to 1.
- Simultaneous `ld_pc` and `inc_pc`: `ld_pc` wins.
- Simultaneous `halt` and `enable`=0: no effect; halt is re-sampled on the next enabled edge.

## Test plan
- Reset, then `enable`=1 for 9 cycles with no strobes: `ph` runs 0,1,...,7,0,1; `pc`=0; `instr_cnt`=1 after the 7->0 wrap.
- `AWIDTH`=5, `data_in`=8'hA3, `ld_ir` pulsed one cycle: next cycle `op`=3'b101 and `ir_addr`=5'd3; `addr`=3 when `sel`=0 and `addr`=`pc` when `sel`=1.
- `pc`=31, `inc_pc`=1 for one edge: `pc`=0. `ld_pc`=1 and `inc_pc`=1 together with `ir_addr`=9: `pc`=9, not 10.
- At `ph`=4, `pc`=6, drive `halt`=1 and `inc_pc`=1 together, then toggle `ld_ir`, `ld_pc` and `data_in` for 10 cycles: `halted`=1, `ph`=4, `pc`=6 and `ir` all unchanged throughout.
- `enable`=0 for 3 cycles at `ph`=2 with `ld_ir`=1 and `data_in` changing each cycle: `ph` stays 2 and `ir` is unchanged. On re-enable, `ir` captures the `data_in` present at that edge.
- Assert `rst` asynchronously mid-cycle at `ph`=5, `pc`=12, `instr_cnt`=4: all outputs read 0 before the next edge; after release, counting restarts from `ph`=0.
